instruction_loader: RTL and testbench

Sequencer that fills the instruction memory from the debug unit's byte stream before execution.
- Accepts bytes over a valid/ready handshake and assembles them MSB-first into instruction words.
- Issues one write pulse per word to the instruction memory, which holds its own write pointer.
- Terminates on a HALT word, or flags an error when memory fills first.

---
 rtl/instruction_loader_pkg.sv | 25 ++
 rtl/instruction_loader_byte_word_assembler.sv | 42 ++++
 rtl/instruction_loader.sv | 109 ++++++++++
 tb/tb_instruction_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared constants for the instruction loader: byte width, FSM encodings and
// the default end-of-program marker.
package instruction_loader_pkg;

    localparam int BYTE_SIZE = 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_RECEIVE = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERROR   = 3'd5;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_CLEAR   = S_CLEAR,
        ST_RECEIVE = S_RECEIVE,
        ST_WRITE   = S_WRITE,
        ST_DONE    = S_DONE,
        ST_ERROR   = S_ERROR
    } loader_state_t;

endpackage

// File: rtl/instruction_loader_byte_word_assembler.sv
// Shifts incoming bytes MSB-first into a word and flags the byte that
// completes it.
module byte_word_assembler
    import instruction_loader_pkg::*;
#(
    parameter int WORD_SIZE_IN_BYTES = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  load_en,
    input  logic                                  clear,
    input  logic [BYTE_SIZE-1:0]                  data,
    output logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0] word,
    output logic                                  word_ready
);

    localparam int WORD_W = WORD_SIZE_IN_BYTES * BYTE_SIZE;
    localparam int CNT_W  = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_SIZE_IN_BYTES - 1);

    logic [WORD_W-1:0] shift;
    logic [CNT_W-1:0]  byte_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift      <= '0;
            byte_count <= '0;
        end else if (clear) begin
            byte_count <= '0;
        end else if (load_en) begin
            shift <= (shift << BYTE_SIZE) | WORD_W'(data);
            if (byte_count == LAST_BYTE)
                byte_count <= '0;
            else
                byte_count <= byte_count + CNT_W'(1);
        end
    end

    assign word       = shift;
    assign word_ready = load_en && (byte_count == LAST_BYTE);

endmodule

// File: rtl/instruction_loader.sv
// Loader FSM: clears instruction memory, assembles bytes into words, writes
// them one by one and stops on the halt word or when memory is full.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int WORD_SIZE_IN_BYTES = 4,
    parameter int MEM_SIZE_IN_WORDS  = 10,
    parameter logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0] HALT_WORD =
        (WORD_SIZE_IN_BYTES*BYTE_SIZE)'(DEFAULT_HALT_WORD)
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset,
    input  logic                                      i_load_start,
    input  logic                                      i_abort,
    input  logic [BYTE_SIZE-1:0]                      i_byte,
    input  logic                                      i_byte_valid,
    output logic                                      o_byte_ready,
    output logic                                      o_mem_clear,
    output logic                                      o_instruction_write,
    output logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0]   o_instruction,
    output logic [$clog2(MEM_SIZE_IN_WORDS+1)-1:0]    o_word_count,
    output logic                                      o_busy,
    output logic                                      o_load_done,
    output logic                                      o_load_error
);

    localparam int WORD_W  = WORD_SIZE_IN_BYTES * BYTE_SIZE;
    localparam int COUNT_W = $clog2(MEM_SIZE_IN_WORDS + 1);
    localparam logic [COUNT_W-1:0] LAST_SLOT = COUNT_W'(MEM_SIZE_IN_WORDS - 1);

    loader_state_t     state, next_state;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] last_word;
    logic [COUNT_W-1:0] word_count;
    logic              word_ready;
    logic              byte_xfer;
    logic              clear_fire;
    logic              write_fire;

    // Abort wins over everything, so it also gates the handshake and strobes.
    assign byte_xfer  = (state == ST_RECEIVE) && i_byte_valid && !i_abort;
    assign clear_fire = (state == ST_CLEAR) && !i_abort;
    assign write_fire = (state == ST_WRITE) && !i_abort;

    byte_word_assembler #(
        .WORD_SIZE_IN_BYTES(WORD_SIZE_IN_BYTES)
    ) u_assembler (
        .clk        (i_clk),
        .rst_n      (i_reset),
        .load_en    (byte_xfer),
        .clear      ((state == ST_CLEAR) || (state == ST_WRITE)),
        .data       (i_byte),
        .word       (word),
        .word_ready (word_ready)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (i_abort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (i_load_start) next_state = ST_CLEAR;
                ST_CLEAR:   next_state = ST_RECEIVE;
                ST_RECEIVE: if (word_ready) next_state = ST_WRITE;
                ST_WRITE: begin
                    if (word == HALT_WORD)
                        next_state = ST_DONE;
                    else if (word_count == LAST_SLOT)
                        next_state = ST_ERROR;
                    else
                        next_state = ST_RECEIVE;
                end
                ST_DONE, ST_ERROR: if (i_load_start) next_state = ST_CLEAR;
                default:    next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            word_count <= '0;
            last_word  <= '0;
        end else if (clear_fire) begin
            word_count <= '0;
            last_word  <= '0;
        end else if (write_fire) begin
            word_count <= word_count + COUNT_W'(1);
            last_word  <= word;
        end
    end

    assign o_byte_ready        = (state == ST_RECEIVE) && !i_abort;
    assign o_mem_clear         = clear_fire;
    assign o_instruction_write = write_fire;
    assign o_instruction       = (state == ST_WRITE) ? word : last_word;
    assign o_word_count        = word_count;
    assign o_busy              = (state == ST_CLEAR) || (state == ST_RECEIVE) || (state == ST_WRITE);
    assign o_load_done         = (state == ST_DONE);
    assign o_load_error        = (state == ST_ERROR);

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized bench for instruction_loader against a word-level model of a load.
module tb_instruction_loader;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int          MEM  = 10;

    logic        clk;
    logic        i_reset;
    logic        i_load_start;
    logic        i_abort;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        o_byte_ready;
    logic        o_mem_clear;
    logic        o_instruction_write;
    logic [31:0] o_instruction;
    logic [3:0]  o_word_count;
    logic        o_busy;
    logic        o_load_done;
    logic        o_load_error;

    int checks = 0;
    int passes = 0;
    int clear_cnt = 0;
    logic [31:0] got_q[$];
    logic [7:0]  accepted_q[$];
    logic [31:0] prog_q[$];
    logic [31:0] exp_q[$];
    logic        exp_done;
    logic        exp_error;

    instruction_loader dut (
        .i_clk               (clk),
        .i_reset             (i_reset),
        .i_load_start        (i_load_start),
        .i_abort             (i_abort),
        .i_byte              (i_byte),
        .i_byte_valid        (i_byte_valid),
        .o_byte_ready        (o_byte_ready),
        .o_mem_clear         (o_mem_clear),
        .o_instruction_write (o_instruction_write),
        .o_instruction       (o_instruction),
        .o_word_count        (o_word_count),
        .o_busy              (o_busy),
        .o_load_done         (o_load_done),
        .o_load_error        (o_load_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Records memory writes, clear pulses and accepted bytes as memory would see them.
    always @(negedge clk) begin
        if (o_instruction_write) got_q.push_back(o_instruction);
        if (o_mem_clear) clear_cnt++;
        if (o_byte_ready && i_byte_valid) accepted_q.push_back(i_byte);
    end

    // Expected writes: every word up to and including HALT, or until memory is full.
    task automatic model_load();
        exp_q.delete();
        exp_done  = 1'b0;
        exp_error = 1'b0;
        foreach (prog_q[i]) begin
            exp_q.push_back(prog_q[i]);
            if (prog_q[i] == HALT) begin
                exp_done = 1'b1;
                break;
            end
            if (exp_q.size() == MEM) begin
                exp_error = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        i_load_start = 1'b1;
        @(posedge clk); #1;
        i_load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) begin @(posedge clk); #1; end
        i_byte = b;
        i_byte_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!o_byte_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!o_byte_ready) begin
            checks++;
            $display("[TB] FAIL handshake_timeout: byte %h never accepted, o_byte_ready=%b required 1", b, o_byte_ready);
        end
        @(posedge clk); #1;
        i_byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited = 0;
        @(negedge clk);
        while (o_busy && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        if (o_busy) begin
            checks++;
            $display("[TB] FAIL idle_timeout: o_busy=%b required 0", o_busy);
        end
    endtask

    // Starts a load, feeds the words the model expects to be consumed, waits for the end.
    task automatic run_load(input int max_gap);
        model_load();
        got_q.delete();
        clear_cnt = 0;
        pulse_start();
        foreach (exp_q[i])
            for (int j = 3; j >= 0; j--)
                send_byte(exp_q[i][j*8 +: 8], $urandom_range(0, max_gap));
        wait_idle();
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        #1;
        checks++;
        if ({o_byte_ready, o_mem_clear, o_instruction_write, o_busy, o_load_done, o_load_error} !== 6'b0)
            $display("[TB] FAIL reset_flags: got %b required 000000",
                     {o_byte_ready, o_mem_clear, o_instruction_write, o_busy, o_load_done, o_load_error});
        else passes++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (o_instruction !== 32'h0) $display("[TB] FAIL reset_instruction: got %h required 0", o_instruction);
        else passes++;
        checks++;
        if (o_word_count !== 4'd0) $display("[TB] FAIL reset_word_count: got %0d required 0", o_word_count);
        else passes++;
        checks++;
        if (o_byte_ready !== 1'b0 || o_busy !== 1'b0)
            $display("[TB] FAIL idle_outputs: ready=%b busy=%b required 0 0", o_byte_ready, o_busy);
        else passes++;
    endtask

    task automatic test_halt_program();
        prog_q = '{32'h0102_0304, HALT};
        run_load(20);
        checks++;
        if (clear_cnt !== 1) $display("[TB] FAIL halt_clear_pulses: got %0d required 1", clear_cnt);
        else passes++;
        checks++;
        if (got_q.size() !== exp_q.size()) $display("[TB] FAIL halt_write_count: got %0d required %0d", got_q.size(), exp_q.size());
        else passes++;
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i])
                $display("[TB] FAIL halt_word%0d: got %h required %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]);
            else passes++;
        end
        checks++;
        if (o_load_done !== 1'b1 || o_load_error !== 1'b0)
            $display("[TB] FAIL halt_flags: done=%b error=%b required 1 0", o_load_done, o_load_error);
        else passes++;
        checks++;
        if (o_word_count !== 4'd2) $display("[TB] FAIL halt_word_count: got %0d required 2", o_word_count);
        else passes++;
    endtask

    task automatic test_mem_full();
        prog_q.delete();
        for (int k = 1; k <= 10; k++) prog_q.push_back({4{8'(k)}});
        run_load(2);
        checks++;
        if (got_q.size() !== 10) $display("[TB] FAIL full_write_count: got %0d required 10", got_q.size());
        else passes++;
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i])
                $display("[TB] FAIL full_word%0d: got %h required %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]);
            else passes++;
        end
        checks++;
        if (o_load_error !== exp_error || o_load_done !== exp_done)
            $display("[TB] FAIL full_flags: done=%b error=%b required %b %b", o_load_done, o_load_error, exp_done, exp_error);
        else passes++;
        checks++;
        if (o_word_count !== 4'd10) $display("[TB] FAIL full_word_count: got %0d required 10", o_word_count);
        else passes++;
    endtask

    task automatic test_halt_at_last();
        prog_q.delete();
        for (int k = 0; k < 9; k++) prog_q.push_back({8'($urandom_range(0, 254)), 24'($urandom)});
        prog_q.push_back(HALT);
        run_load(1);
        checks++;
        if (got_q.size() !== 10 || (got_q.size() == 10 && got_q[9] !== HALT))
            $display("[TB] FAIL last_halt_written: writes=%0d required 10 ending in %h", got_q.size(), HALT);
        else passes++;
        checks++;
        if (o_load_done !== 1'b1 || o_load_error !== 1'b0)
            $display("[TB] FAIL last_halt_flags: done=%b error=%b required 1 0", o_load_done, o_load_error);
        else passes++;
        checks++;
        if (o_word_count !== 4'd10) $display("[TB] FAIL last_halt_word_count: got %0d required 10", o_word_count);
        else passes++;
    endtask

    task automatic test_abort();
        got_q.delete();
        clear_cnt = 0;
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 254)), $urandom_range(0, 3));
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_byte_ready !== 1'b0)
            $display("[TB] FAIL abort_to_idle: busy=%b ready=%b required 0 0", o_busy, o_byte_ready);
        else passes++;
        repeat (6) @(negedge clk);
        checks++;
        if (got_q.size() !== 2) $display("[TB] FAIL abort_no_write: writes=%0d required 2", got_q.size());
        else passes++;
        checks++;
        if (o_word_count !== 4'd2) $display("[TB] FAIL abort_word_count: got %0d required 2", o_word_count);
        else passes++;
        // Abort and start together: abort wins, loader stays idle.
        @(posedge clk); #1;
        i_abort = 1'b1;
        i_load_start = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        i_load_start = 1'b0;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || clear_cnt !== 1)
            $display("[TB] FAIL abort_priority: busy=%b clears=%0d required 0 1", o_busy, clear_cnt);
        else passes++;
        clear_cnt = 0;
        pulse_start();
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (clear_cnt !== 1 || o_word_count !== 4'd0 || o_byte_ready !== 1'b1)
            $display("[TB] FAIL restart: clears=%0d count=%0d ready=%b required 1 0 1", clear_cnt, o_word_count, o_byte_ready);
        else passes++;
        @(posedge clk); #1;
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
    endtask

    task automatic test_hold_through_write();
        logic [7:0] seq [4];
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        pulse_start();
        accepted_q.delete();
        foreach (seq[i]) send_byte(seq[i], 0);
        // Re-raise valid on the WRITE cycle and hold it until the byte is taken.
        i_byte = 8'hAA;
        i_byte_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (o_instruction_write !== 1'b1 || o_byte_ready !== 1'b0 || o_instruction !== 32'h1122_3344)
            $display("[TB] FAIL write_cycle: write=%b ready=%b word=%h required 1 0 11223344",
                     o_instruction_write, o_byte_ready, o_instruction);
        else passes++;
        checks++;
        if (accepted_q.size() !== 4) $display("[TB] FAIL no_xfer_in_write: accepted=%0d required 4", accepted_q.size());
        else passes++;
        @(negedge clk);
        @(posedge clk); #1;
        i_byte_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (accepted_q.size() !== 5 || accepted_q[accepted_q.size()-1] !== 8'hAA)
            $display("[TB] FAIL held_byte: accepted=%0d last=%h required 5 aa", accepted_q.size(),
                     accepted_q.size() > 0 ? accepted_q[accepted_q.size()-1] : 8'hx);
        else passes++;
        @(posedge clk); #3;
        i_reset = 1'b0;
        #1;
        checks++;
        if ({o_byte_ready, o_mem_clear, o_instruction_write, o_busy, o_load_done, o_load_error} !== 6'b0 ||
            o_instruction !== 32'h0 || o_word_count !== 4'd0)
            $display("[TB] FAIL async_reset: flags=%b word=%h count=%0d required 000000 0 0",
                     {o_byte_ready, o_mem_clear, o_instruction_write, o_busy, o_load_done, o_load_error},
                     o_instruction, o_word_count);
        else passes++;
        @(negedge clk);
        i_reset = 1'b1;
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 12);
            prog_q.delete();
            for (int i = 0; i < n; i++)
                prog_q.push_back(($urandom_range(0, 7) == 0) ? HALT : {8'($urandom_range(0, 254)), 24'($urandom)});
            if (n <= MEM) prog_q[n-1] = HALT;
            run_load(3);
            checks++;
            if (got_q != exp_q) $display("[TB] FAIL random%0d_writes: got %0d words required %0d", r, got_q.size(), exp_q.size());
            else passes++;
            checks++;
            if (o_load_done !== exp_done || o_load_error !== exp_error || o_word_count !== 4'(exp_q.size()))
                $display("[TB] FAIL random%0d_end: done=%b error=%b count=%0d required %b %b %0d", r,
                         o_load_done, o_load_error, o_word_count, exp_done, exp_error, exp_q.size());
            else passes++;
        end
    endtask

    initial begin
        i_reset      = 1'b0;
        i_load_start = 1'b0;
        i_abort      = 1'b0;
        i_byte       = 8'h00;
        i_byte_valid = 1'b0;
        test_reset();
        test_halt_program();
        test_mem_full();
        test_halt_at_last();
        test_abort();
        test_hold_through_write();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
